fwd_hazard_unit: RTL and testbench

- Generalised forwarding and hazard block for the 5-stage pipeline with a multi-cycle multiplier.
- Selects EX operands 1/2 from four sources: register file, EX/MEM ALU result, multiplier completion, MEM/WB writeback.
- Tracks in-flight multiplies in a scoreboard and raises stall for load-use, multiply RAW and multiply WAW hazards.
- Sits beside the ID/EX register; `stall` freezes PC and IF/ID and injects a bubble into ID/EX.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/mul_scoreboard.sv | 42 ++++
 rtl/fwd_hazard_unit.sv | 161 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings and types for the forwarding / hazard unit.
package fwd_pkg;

  // Operand source encoding presented on fwd_sel1/fwd_sel2
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MUL   = 2'd2;
  localparam logic [1:0] FWD_MEMWB = 2'd3;

  // Default register index width of the core
  localparam int SB_RD_W = 5;

  // One in-flight multiply as tracked by the scoreboard
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/mul_scoreboard.sv
// Shift register tracking in-flight multiplies from EX until their result
// appears on the multiplier output (tail stage).
module mul_scoreboard
  import fwd_pkg::*;
#(
  parameter int MUL_LAT    = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  input  logic [REG_ADDR_W-1:0]                issue_rd,
  output logic [MUL_LAT-1:0]                   stage_valid,
  output logic [MUL_LAT-1:0][REG_ADDR_W-1:0]   stage_rd,
  output logic                                 tail_valid,
  output logic [REG_ADDR_W-1:0]                tail_rd
);

  // Valid bits advance every cycle; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= issue_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1];
      end
    end
  end

  // Destination indices ride alongside the valids; only meaningful when valid
  always_ff @(posedge clk) begin
    stage_rd[0] <= issue_rd;
    for (int i = 1; i < MUL_LAT; i++) begin
      stage_rd[i] <= stage_rd[i-1];
    end
  end

  assign tail_valid = stage_valid[MUL_LAT-1];
  assign tail_rd    = stage_rd[MUL_LAT-1];

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard detection for the 5-stage pipeline with a
// multi-cycle multiplier. Stall freezes PC/IF-ID and bubbles ID/EX.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [DATA_W-1:0]     ex_reg1_data,
  input  logic [DATA_W-1:0]     ex_reg2_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic                  ex_is_mul,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [DATA_W-1:0]     exmem_alu_data,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [DATA_W-1:0]     memwb_wb_data,
  input  logic [DATA_W-1:0]     mul_res_data,
  output logic [DATA_W-1:0]     ex_op1,
  output logic [DATA_W-1:0]     ex_op2,
  output logic [1:0]            fwd_sel1,
  output logic [1:0]            fwd_sel2,
  output logic                  mul_wb_valid,
  output logic [REG_ADDR_W-1:0] mul_wb_rd,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  // An EX multiply must be waited on by a dependent reader unless its result
  // reaches the tail in time for that reader's EX (only true for MUL_LAT=1)
  localparam bit EX_MUL_RAW = (MUL_LAT >= 2);

  logic [MUL_LAT-1:0]                 sb_valid;
  logic [MUL_LAT-1:0][REG_ADDR_W-1:0] sb_rd;
  logic                               sb_tail_valid;
  logic [REG_ADDR_W-1:0]              sb_tail_rd;
  logic                               ex_mul_wr;
  logic                               ld_use;
  logic                               mul_raw;
  logic                               mul_waw;

  assign ex_mul_wr = ex_valid & ex_is_mul & ex_reg_write;

  mul_scoreboard #(
    .MUL_LAT    (MUL_LAT),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (ex_mul_wr && (ex_rd != '0)),
    .issue_rd    (ex_rd),
    .stage_valid (sb_valid),
    .stage_rd    (sb_rd),
    .tail_valid  (sb_tail_valid),
    .tail_rd     (sb_tail_rd)
  );

  assign mul_wb_valid = sb_tail_valid & ~rst;
  assign mul_wb_rd    = sb_tail_rd;

  // Forwarding source for one EX operand; x0 never forwards and the
  // youngest writer (EX/MEM) wins over the retiring multiply
  function automatic logic [1:0] pick_src(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  em_we,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic                  mu_v,
    input logic [REG_ADDR_W-1:0] mu_rd,
    input logic                  mw_we,
    input logic [REG_ADDR_W-1:0] mw_rd
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (rs != '0) begin
      if (em_we && (em_rd == rs))      sel = FWD_EXMEM;
      else if (mu_v && (mu_rd == rs))  sel = FWD_MUL;
      else if (mw_we && (mw_rd == rs)) sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  function automatic logic [DATA_W-1:0] pick_data(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] em,
    input logic [DATA_W-1:0] mu,
    input logic [DATA_W-1:0] mw
  );
    logic [DATA_W-1:0] d;
    case (sel)
      FWD_EXMEM: d = em;
      FWD_MUL:   d = mu;
      FWD_MEMWB: d = mw;
      default:   d = rf;
    endcase
    return d;
  endfunction

  // A used, non-zero ID source that matches a given destination
  function automatic logic src_hit(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  used,
    input logic [REG_ADDR_W-1:0] rd
  );
    return used && (rs != '0) && (rs == rd);
  endfunction

  assign fwd_sel1 = pick_src(ex_rs1, exmem_reg_write, exmem_rd, mul_wb_valid, mul_wb_rd,
                             memwb_reg_write, memwb_rd);
  assign fwd_sel2 = pick_src(ex_rs2, exmem_reg_write, exmem_rd, mul_wb_valid, mul_wb_rd,
                             memwb_reg_write, memwb_rd);
  assign ex_op1   = pick_data(fwd_sel1, ex_reg1_data, exmem_alu_data, mul_res_data, memwb_wb_data);
  assign ex_op2   = pick_data(fwd_sel2, ex_reg2_data, exmem_alu_data, mul_res_data, memwb_wb_data);

  // Hazard detection: load-use, multiply RAW and multiply WAW
  always_comb begin
    ld_use  = ex_valid && ex_is_load && ex_reg_write &&
              (src_hit(id_rs1, id_rs1_used, ex_rd) || src_hit(id_rs2, id_rs2_used, ex_rd));
    mul_raw = EX_MUL_RAW && ex_mul_wr &&
              (src_hit(id_rs1, id_rs1_used, ex_rd) || src_hit(id_rs2, id_rs2_used, ex_rd));
    mul_waw = ex_mul_wr && id_reg_write && (id_rd != '0) && (id_rd == ex_rd);
    for (int k = 0; k < MUL_LAT; k++) begin
      // Entries at stage MUL_LAT-2 reach the tail exactly when the reader hits EX
      if (sb_valid[k] && (k < MUL_LAT - 2) &&
          (src_hit(id_rs1, id_rs1_used, sb_rd[k]) || src_hit(id_rs2, id_rs2_used, sb_rd[k])))
        mul_raw = 1'b1;
      // The tail writes back this cycle, ahead of any younger writer
      if (sb_valid[k] && (k < MUL_LAT - 1) && id_reg_write &&
          (id_rd != '0) && (id_rd == sb_rd[k]))
        mul_waw = 1'b1;
    end
  end

  assign stall = ~rst & (ld_use | mul_raw | mul_waw);

  // Saturating count of stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus pushes cycle-tagged expected
// values, a monitor on the falling edge pops and compares them.
module tb_fwd_hazard_unit;

  localparam int DATA_W  = 32;
  localparam int RA      = 5;
  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 4;

  localparam int K_OP1 = 0, K_OP2 = 1, K_SEL1 = 2, K_SEL2 = 3;
  localparam int K_STALL = 4, K_WBV = 5, K_WBRD = 6, K_CNT = 7;

  localparam logic [31:0] REG1 = 32'hAAAA0001;
  localparam logic [31:0] REG2 = 32'hBBBB0002;

  logic              clk = 1'b0;
  logic              rst;
  logic [RA-1:0]     id_rs1, id_rs2, id_rd;
  logic              id_rs1_used, id_rs2_used, id_reg_write;
  logic              ex_valid;
  logic [RA-1:0]     ex_rs1, ex_rs2, ex_rd;
  logic [DATA_W-1:0] ex_reg1_data, ex_reg2_data;
  logic              ex_reg_write, ex_is_load, ex_is_mul;
  logic [RA-1:0]     exmem_rd, memwb_rd;
  logic              exmem_reg_write, memwb_reg_write;
  logic [DATA_W-1:0] exmem_alu_data, memwb_wb_data, mul_res_data;
  logic [DATA_W-1:0] ex_op1, ex_op2;
  logic [1:0]        fwd_sel1, fwd_sel2;
  logic              mul_wb_valid;
  logic [RA-1:0]     mul_wb_rd;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_hazard_unit #(
    .DATA_W (DATA_W), .REG_ADDR_W (RA), .MUL_LAT (MUL_LAT), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_rs1_used (id_rs1_used), .id_rs2_used (id_rs2_used),
    .id_rd (id_rd), .id_reg_write (id_reg_write),
    .ex_valid (ex_valid), .ex_rs1 (ex_rs1), .ex_rs2 (ex_rs2),
    .ex_reg1_data (ex_reg1_data), .ex_reg2_data (ex_reg2_data),
    .ex_rd (ex_rd), .ex_reg_write (ex_reg_write),
    .ex_is_load (ex_is_load), .ex_is_mul (ex_is_mul),
    .exmem_rd (exmem_rd), .exmem_reg_write (exmem_reg_write), .exmem_alu_data (exmem_alu_data),
    .memwb_rd (memwb_rd), .memwb_reg_write (memwb_reg_write), .memwb_wb_data (memwb_wb_data),
    .mul_res_data (mul_res_data),
    .ex_op1 (ex_op1), .ex_op2 (ex_op2), .fwd_sel1 (fwd_sel1), .fwd_sel2 (fwd_sel2),
    .mul_wb_valid (mul_wb_valid), .mul_wb_rd (mul_wb_rd),
    .stall (stall), .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_OP1:   return ex_op1;
      K_OP2:   return ex_op2;
      K_SEL1:  return {30'd0, fwd_sel1};
      K_SEL2:  return {30'd0, fwd_sel2};
      K_STALL: return {31'd0, stall};
      K_WBV:   return {31'd0, mul_wb_valid};
      K_WBRD:  return {27'd0, mul_wb_rd};
      default: return {28'd0, stall_cnt};
    endcase
  endfunction

  task automatic expect_v(int kind, logic [31:0] val, string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_write = 1'b0;
    ex_valid = 1'b0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    ex_reg1_data = REG1; ex_reg2_data = REG2;
    ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_is_mul = 1'b0;
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_alu_data = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_wb_data = '0;
    mul_res_data = '0;
  endtask

  task automatic reset_cycle();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic ex_instr(logic [RA-1:0] rd, logic load, logic mul);
    ex_valid = 1'b1; ex_rd = rd; ex_reg_write = 1'b1; ex_is_load = load; ex_is_mul = mul;
  endtask

  task automatic id_instr(logic [RA-1:0] rs1, logic u1, logic [RA-1:0] rs2, logic u2,
                          logic [RA-1:0] rd, logic we);
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = we;
  endtask

  // Monitor: compares every expectation tagged for the current cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || observe(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", e.name, e.cyc, observe(e.kind), e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    step();
    // Reset state: a live load-use hazard must not stall while rst=1
    ex_instr(5'd7, 1'b1, 1'b0);
    id_instr(5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1);
    expect_v(K_STALL, 0, "rst_stall");
    expect_v(K_WBV,   0, "rst_wbv");
    expect_v(K_CNT,   0, "rst_cnt");
    step();
    idle();
    rst = 1'b0;
    expect_v(K_CNT, 0, "rst_cnt_hold");
    step();

    // Reset during an in-flight multiply discards it
    ex_instr(5'd5, 1'b0, 1'b1);
    expect_v(K_STALL, 0, "rmul_issue_stall");
    step();
    idle();
    rst = 1'b1;
    expect_v(K_WBV, 0, "rmul_wbv_a1");
    step();
    rst = 1'b0;
    expect_v(K_WBV, 0, "rmul_wbv_a2");
    expect_v(K_CNT, 0, "rmul_cnt");
    step();
    expect_v(K_WBV, 0, "rmul_wbv_a3");
    step();
    expect_v(K_WBV, 0, "rmul_wbv_a4");
    step();

    // Plain forwarding priorities
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_alu_data = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_wb_data = 32'h22;
    ex_rs1 = 5'd3; ex_rs2 = 5'd0;
    expect_v(K_OP1,  32'h11, "fwd_exmem_op1");
    expect_v(K_SEL1, 1,      "fwd_exmem_sel1");
    expect_v(K_OP2,  REG2,   "fwd_x0_op2");
    expect_v(K_SEL2, 0,      "fwd_x0_sel2");
    step();
    exmem_reg_write = 1'b0;
    expect_v(K_OP1,  32'h22, "fwd_memwb_op1");
    expect_v(K_SEL1, 3,      "fwd_memwb_sel1");
    step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; ex_rs1 = 5'd0;
    expect_v(K_OP1,  REG1, "fwd_rd0_op1");
    expect_v(K_SEL1, 0,    "fwd_rd0_sel1");
    step();

    // Load-use: one stall, then MEM/WB forwarding
    reset_cycle();
    ex_instr(5'd7, 1'b1, 1'b0);
    id_instr(5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1);
    expect_v(K_STALL, 1, "lu_stall_c0");
    step();
    ex_valid = 1'b0; ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    expect_v(K_STALL, 0, "lu_stall_c1");
    step();
    idle();
    ex_valid = 1'b1; ex_rs1 = 5'd7; ex_rs2 = 5'd1; ex_rd = 5'd8; ex_reg_write = 1'b1;
    memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_wb_data = 32'hDEAD;
    expect_v(K_OP1,  32'hDEAD, "lu_op1");
    expect_v(K_SEL1, 3,        "lu_sel1");
    expect_v(K_OP2,  REG2,     "lu_op2");
    expect_v(K_CNT,  1,        "lu_cnt");
    step();

    // Multiply RAW: two stalls, dependent operand taken from the tail
    reset_cycle();
    ex_instr(5'd4, 1'b0, 1'b1);
    id_instr(5'd4, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1);
    expect_v(K_STALL, 1, "raw_stall_c0");
    step();
    ex_valid = 1'b0; ex_reg_write = 1'b0; ex_is_mul = 1'b0; ex_rd = '0;
    expect_v(K_STALL, 1, "raw_stall_c1");
    step();
    expect_v(K_STALL, 0, "raw_stall_c2");
    expect_v(K_WBV,   0, "raw_wbv_c2");
    step();
    idle();
    ex_valid = 1'b1; ex_rs1 = 5'd4; ex_rs2 = 5'd2; ex_rd = 5'd6; ex_reg_write = 1'b1;
    mul_res_data = 32'h1234;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_wb_data = 32'h5555;
    expect_v(K_WBV,   1,       "raw_wbv_c3");
    expect_v(K_WBRD,  4,       "raw_wbrd_c3");
    expect_v(K_OP1,   32'h1234, "raw_op1");
    expect_v(K_SEL1,  2,       "raw_sel1");
    expect_v(K_SEL2,  0,       "raw_sel2");
    expect_v(K_STALL, 0,       "raw_stall_c3");
    expect_v(K_CNT,   2,       "raw_cnt");
    step();
    idle();
    expect_v(K_WBV, 0, "raw_wbv_c4");
    step();

    // Multiply WAW: three stalls; EX/MEM beats the tail; issue while retiring
    reset_cycle();
    ex_instr(5'd9, 1'b0, 1'b1);
    id_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
    expect_v(K_STALL, 1, "waw_stall_c0");
    step();
    ex_valid = 1'b0; ex_reg_write = 1'b0; ex_is_mul = 1'b0; ex_rd = '0;
    expect_v(K_STALL, 1, "waw_stall_c1");
    expect_v(K_WBV,   0, "waw_wbv_c1");
    step();
    expect_v(K_STALL, 1, "waw_stall_c2");
    step();
    ex_instr(5'd10, 1'b0, 1'b1);
    ex_rs1 = 5'd9; mul_res_data = 32'h7777;
    exmem_reg_write = 1'b1; exmem_rd = 5'd9; exmem_alu_data = 32'h99;
    expect_v(K_STALL, 0,     "waw_stall_c3");
    expect_v(K_WBV,   1,     "waw_wbv_c3");
    expect_v(K_WBRD,  9,     "waw_wbrd_c3");
    expect_v(K_OP1,   32'h99, "waw_exmem_wins_op1");
    expect_v(K_SEL1,  1,     "waw_exmem_wins_sel1");
    expect_v(K_CNT,   3,     "waw_cnt_c3");
    step();
    idle();
    ex_valid = 1'b1; ex_rs1 = 5'd1; ex_rd = 5'd9; ex_reg_write = 1'b1;
    expect_v(K_WBV, 0, "waw_wbv_c4");
    expect_v(K_CNT, 3, "waw_cnt_c4");
    step();
    idle();
    expect_v(K_WBV, 0, "waw_wbv_c5");
    step();
    expect_v(K_WBV,  1,  "waw2_wbv_c6");
    expect_v(K_WBRD, 10, "waw2_wbrd_c6");
    step();

    // Saturation of the stall counter
    reset_cycle();
    for (int i = 0; i < 20; i++) begin
      ex_instr(5'd7, 1'b1, 1'b0);
      id_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
      if (i == 0)  expect_v(K_STALL, 1, "sat_stall_first");
      if (i == 14) expect_v(K_CNT, 14, "sat_cnt_14");
      step();
    end
    idle();
    expect_v(K_CNT,   15, "sat_cnt_15");
    expect_v(K_STALL, 0,  "sat_stall_off");
    step();
    ex_instr(5'd7, 1'b1, 1'b0);
    id_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
    step();
    step();
    idle();
    expect_v(K_CNT, 15, "sat_cnt_hold");
    step();

    // x0 hazards never stall and never enter the scoreboard
    ex_instr(5'd0, 1'b0, 1'b1);
    id_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    expect_v(K_STALL, 0, "x0_mul_stall");
    step();
    ex_instr(5'd0, 1'b1, 1'b0);
    expect_v(K_STALL, 0, "x0_load_stall");
    expect_v(K_WBV,   0, "x0_wbv_1");
    step();
    idle();
    expect_v(K_WBV, 0, "x0_wbv_2");
    step();
    expect_v(K_WBV, 0, "x0_wbv_3");
    expect_v(K_CNT, 15, "x0_cnt");
    step();
    step();
    step();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
